// File: rtl/decode_pkg.sv
// rtl/decode_pkg.sv - opcode, op-class, state and decoded-field types for the decode stage
package decode_pkg;

  typedef enum logic [2:0] {
    OPC_LOGIC = 3'b000,
    OPC_BLT   = 3'b001,
    OPC_LOAD  = 3'b010,
    OPC_ARITH = 3'b011,
    OPC_SHIFT = 3'b100,
    OPC_BEQ   = 3'b101,
    OPC_STORE = 3'b110,
    OPC_JMPX  = 3'b111
  } opcode_e;

  // Classes 0..7 share their encoding with opcode_e so single-beat decode is a plain cast.
  typedef enum logic [3:0] {
    OP_LOGIC = 4'd0,
    OP_BLT   = 4'd1,
    OP_LOAD  = 4'd2,
    OP_ARITH = 4'd3,
    OP_SHIFT = 4'd4,
    OP_BEQ   = 4'd5,
    OP_STORE = 4'd6,
    OP_JMPX  = 4'd7,
    OP_LDI   = 4'd8,
    OP_ILL   = 4'd9
  } op_e;

  typedef enum logic {
    IDLE   = 1'b0,
    PREFIX = 1'b1
  } state_e;

  // Fixed-width decoded fields; the IMM_W-wide immediate travels alongside as its own signal.
  typedef struct packed {
    op_e        op;
    logic [1:0] rs1;
    logic [1:0] rs2;
    logic       use1;
    logic       use2;
    logic       fn;
    logic       illegal;
  } dec_t;

endpackage

// File: rtl/decode_stage_if.sv
// rtl/decode_stage_if.sv - byte input and decoded output handshake interfaces of the decode stage
interface decode_in_if;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_inst;

  modport master (output in_valid, output in_inst, input in_ready);
  modport slave  (input in_valid, input in_inst, output in_ready);
endinterface

interface decode_out_if #(
  parameter int IMM_W = 8
);
  logic             out_valid;
  logic             out_ready;
  decode_pkg::op_e  out_op;
  logic [1:0]       out_rs1;
  logic [1:0]       out_rs2;
  logic             out_use1;
  logic             out_use2;
  logic             out_fn;
  logic [IMM_W-1:0] out_imm;
  logic             out_illegal;

  modport master (
    output out_valid, output out_op, output out_rs1, output out_rs2, output out_use1,
    output out_use2, output out_fn, output out_imm, output out_illegal, input out_ready
  );
  modport slave (
    input out_valid, input out_op, input out_rs1, input out_rs2, input out_use1,
    input out_use2, input out_fn, input out_imm, input out_illegal, output out_ready
  );
endinterface

// File: rtl/decode_fields.sv
// rtl/decode_fields.sv - combinational byte to decoded-field extraction
// The 111/i3=0 prefix encoding is reported illegal here; the stage intercepts it when LDI is enabled.
module decode_fields import decode_pkg::*; #(
  parameter int IMM_W   = 8,
  parameter bit BR_SEXT = 1'b1
) (
  input  logic [7:0]       inst_i,
  output dec_t             dec_o,
  output logic [IMM_W-1:0] imm_o
);

  logic [IMM_W-1:0] br3_imm;
  logic [IMM_W-1:0] br4_imm;

  assign br3_imm = BR_SEXT ? {{(IMM_W-3){inst_i[5]}}, inst_i[5:3]} : IMM_W'(inst_i[5:3]);
  assign br4_imm = BR_SEXT ? {{(IMM_W-4){inst_i[7]}}, inst_i[7:4]} : IMM_W'(inst_i[7:4]);

  always_comb begin
    dec_o = '0;
    imm_o = '0;
    case (opcode_e'(inst_i[2:0]))
      OPC_LOGIC, OPC_ARITH, OPC_SHIFT: begin
        dec_o.op   = op_e'({1'b0, inst_i[2:0]});
        dec_o.rs1  = {inst_i[4], inst_i[6]};
        dec_o.rs2  = {inst_i[5], inst_i[7]};
        dec_o.fn   = inst_i[3];
        dec_o.use1 = 1'b1;
        dec_o.use2 = 1'b1;
      end
      OPC_BLT, OPC_BEQ: begin
        dec_o.op   = op_e'({1'b0, inst_i[2:0]});
        dec_o.rs1  = {1'b0, inst_i[6]};
        dec_o.rs2  = {1'b0, inst_i[7]};
        dec_o.use1 = 1'b1;
        dec_o.use2 = 1'b1;
        imm_o      = br3_imm;
      end
      OPC_LOAD: begin
        dec_o.op   = OP_LOAD;
        dec_o.rs1  = {1'b0, inst_i[7]};
        dec_o.use1 = 1'b1;
        imm_o      = IMM_W'(inst_i[6:3]);
      end
      OPC_STORE: begin
        dec_o.op   = OP_STORE;
        dec_o.rs1  = {1'b0, inst_i[6]};
        dec_o.rs2  = {1'b0, inst_i[7]};
        dec_o.use1 = 1'b1;
        dec_o.use2 = 1'b1;
        imm_o      = IMM_W'(inst_i[5:3]);
      end
      OPC_JMPX: begin
        if (inst_i[3]) begin
          dec_o.op = OP_JMPX;
          dec_o.fn = 1'b1;
          imm_o    = br4_imm;
        end else begin
          dec_o.op      = OP_ILL;
          dec_o.illegal = 1'b1;
        end
      end
    endcase
  end

endmodule

// File: rtl/decode_stage.sv
// rtl/decode_stage.sv - registered, handshaked 8-bit instruction decode stage
// DECODE_LDI_EN enables the two-byte load-immediate prefix FSM (IDLE/PREFIX).
module decode_stage import decode_pkg::*; #(
  parameter int IMM_W   = 8,
  parameter bit BR_SEXT = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  decode_in_if.slave   in_if,
  decode_out_if.master out_if
);

  dec_t             dec_w;
  dec_t             out_d, out_q;
  logic [IMM_W-1:0] imm_w;
  logic [IMM_W-1:0] imm_d, imm_q;
  logic             out_valid_d, out_valid_q;
  logic             in_fire;

  decode_fields #(
    .IMM_W   (IMM_W),
    .BR_SEXT (BR_SEXT)
  ) u_fields (
    .inst_i (in_if.in_inst),
    .dec_o  (dec_w),
    .imm_o  (imm_w)
  );

  assign in_if.in_ready = !out_valid_q || out_if.out_ready;
  assign in_fire        = in_if.in_valid && in_if.in_ready;

`ifdef DECODE_LDI_EN
  localparam logic [0:0] ST_IDLE   = IDLE;
  localparam logic [0:0] ST_PREFIX = PREFIX;

  logic [0:0] state_d, state_q;
  logic [1:0] rd_d, rd_q;
  logic       is_prefix;

  assign is_prefix = (in_if.in_inst[2:0] == OPC_JMPX) && !in_if.in_inst[3];

  // A prefix beat produces no result, so the output register simply keeps draining.
  always_comb begin
    out_valid_d = out_valid_q && !out_if.out_ready;
    out_d       = out_q;
    imm_d       = imm_q;
    state_d     = state_q;
    rd_d        = rd_q;
    if (flush) begin
      out_valid_d = 1'b0;
      state_d     = ST_IDLE;
    end else if (in_fire) begin
      if (state_q == ST_PREFIX) begin
        out_d       = '0;
        out_d.op    = OP_LDI;
        out_d.rs1   = rd_q;
        out_d.use1  = 1'b1;
        imm_d       = IMM_W'(in_if.in_inst);
        out_valid_d = 1'b1;
        state_d     = ST_IDLE;
      end else if (is_prefix) begin
        rd_d    = in_if.in_inst[5:4];
        state_d = ST_PREFIX;
      end else begin
        out_d       = dec_w;
        imm_d       = imm_w;
        out_valid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      rd_q    <= '0;
    end else begin
      state_q <= state_d;
      rd_q    <= rd_d;
    end
  end
`else
  always_comb begin
    out_valid_d = out_valid_q && !out_if.out_ready;
    out_d       = out_q;
    imm_d       = imm_q;
    if (flush) begin
      out_valid_d = 1'b0;
    end else if (in_fire) begin
      out_d       = dec_w;
      imm_d       = imm_w;
      out_valid_d = 1'b1;
    end
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_q       <= '0;
      imm_q       <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_q       <= out_d;
      imm_q       <= imm_d;
    end
  end

  assign out_if.out_valid   = out_valid_q;
  assign out_if.out_op      = out_q.op;
  assign out_if.out_rs1     = out_q.rs1;
  assign out_if.out_rs2     = out_q.rs2;
  assign out_if.out_use1    = out_q.use1;
  assign out_if.out_use2    = out_q.use2;
  assign out_if.out_fn      = out_q.fn;
  assign out_if.out_illegal = out_q.illegal;
  assign out_if.out_imm     = imm_q;

endmodule

// File: tb/tb_decode_stage.sv
// tb/tb_decode_stage.sv - table-driven bench for decode_stage (BR_SEXT=1/IMM_W=8 and BR_SEXT=0/IMM_W=12)
module tb_decode_stage;
  import decode_pkg::*;

  logic clk;
  logic rst;
  logic flush;

  decode_in_if                 in_if ();
  decode_out_if #(.IMM_W(8))   out_if ();
  decode_in_if                 in0_if ();
  decode_out_if #(.IMM_W(12))  out0_if ();

  decode_stage #(.IMM_W(8), .BR_SEXT(1'b1)) dut (
    .clk    (clk),
    .rst    (rst),
    .flush  (flush),
    .in_if  (in_if),
    .out_if (out_if)
  );

  decode_stage #(.IMM_W(12), .BR_SEXT(1'b0)) dut0 (
    .clk    (clk),
    .rst    (rst),
    .flush  (flush),
    .in_if  (in0_if),
    .out_if (out0_if)
  );

  assign in0_if.in_valid   = in_if.in_valid;
  assign in0_if.in_inst    = in_if.in_inst;
  assign out0_if.out_ready = 1'b1;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic [7:0]  inst;
    logic [3:0]  op;
    logic [1:0]  rs1;
    logic [1:0]  rs2;
    logic        u1;
    logic        u2;
    logic        fn;
    logic        ill;
    logic [7:0]  imm;
    logic [11:0] imm0;
  } vec_t;

  vec_t vecs[10];

  function automatic logic [31:0] pack(input logic v, input logic [3:0] op, input logic [1:0] rs1,
                                       input logic [1:0] rs2, input logic u1, input logic u2,
                                       input logic fn, input logic ill, input logic [7:0] imm);
    return {11'b0, v, op, rs1, rs2, u1, u2, fn, ill, imm};
  endfunction

  function automatic logic [31:0] snap();
    return pack(out_if.out_valid, out_if.out_op, out_if.out_rs1, out_if.out_rs2, out_if.out_use1,
                out_if.out_use2, out_if.out_fn, out_if.out_illegal, out_if.out_imm);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    in_if.in_valid = 1'b1;
    in_if.in_inst  = b;
    cyc();
    in_if.in_valid = 1'b0;
  endtask

  initial begin
    vecs[0] = '{8'h90, 4'd0, 2'b10, 2'b01, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 12'h000};
    vecs[1] = '{8'h39, 4'd1, 2'b00, 2'b00, 1'b1, 1'b1, 1'b0, 1'b0, 8'hFF, 12'h007};
    vecs[2] = '{8'hFB, 4'd3, 2'b11, 2'b11, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 12'h000};
    vecs[3] = '{8'h5C, 4'd4, 2'b11, 2'b00, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 12'h000};
    vecs[4] = '{8'h65, 4'd5, 2'b01, 2'b00, 1'b1, 1'b1, 1'b0, 1'b0, 8'hFC, 12'h004};
    vecs[5] = '{8'h95, 4'd5, 2'b00, 2'b01, 1'b1, 1'b1, 1'b0, 1'b0, 8'h02, 12'h002};
    vecs[6] = '{8'hDA, 4'd2, 2'b01, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 8'h0B, 12'h00B};
    vecs[7] = '{8'hAE, 4'd6, 2'b00, 2'b01, 1'b1, 1'b1, 1'b0, 1'b0, 8'h05, 12'h005};
    vecs[8] = '{8'h8F, 4'd7, 2'b00, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 8'hF8, 12'h008};
    vecs[9] = '{8'h7F, 4'd7, 2'b00, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 8'h07, 12'h007};

    rst              = 1'b1;
    flush            = 1'b0;
    in_if.in_valid   = 1'b0;
    in_if.in_inst    = 8'h00;
    out_if.out_ready = 1'b1;
    cyc();
    cyc();
    check("reset_outputs", snap(), 32'h0);
    check("reset_in_ready", {31'b0, in_if.in_ready}, 32'h1);
    rst = 1'b0;
    cyc();
    check("idle_after_reset", snap(), 32'h0);

    for (int k = 0; k < 10; k++) begin
      send(vecs[k].inst);
      check($sformatf("vec_%02h", vecs[k].inst), snap(),
            pack(1'b1, vecs[k].op, vecs[k].rs1, vecs[k].rs2, vecs[k].u1, vecs[k].u2,
                 vecs[k].fn, vecs[k].ill, vecs[k].imm));
      check($sformatf("vec_%02h_zext12", vecs[k].inst), {20'b0, out0_if.out_imm},
            {20'b0, vecs[k].imm0});
    end
    cyc();
    check("table_drain", {31'b0, out_if.out_valid}, 32'h0);

    out_if.out_ready = 1'b0;
    send(8'h90);
    in_if.in_valid = 1'b1;
    in_if.in_inst  = 8'h39;
    for (int c = 0; c < 3; c++) begin
      check($sformatf("stall%0d_hold", c), snap(),
            pack(1'b1, 4'd0, 2'b10, 2'b01, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00));
      check($sformatf("stall%0d_in_ready", c), {31'b0, in_if.in_ready}, 32'h0);
      cyc();
    end
    out_if.out_ready = 1'b1;
    #1;
    check("release_in_ready", {31'b0, in_if.in_ready}, 32'h1);
    cyc();
    in_if.in_valid = 1'b0;
    check("release_next", snap(), pack(1'b1, 4'd1, 2'b00, 2'b00, 1'b1, 1'b1, 1'b0, 1'b0, 8'hFF));
    cyc();
    check("release_drain", {31'b0, out_if.out_valid}, 32'h0);

    send(8'h27);
`ifdef DECODE_LDI_EN
    check("ldi_prefix_silent", {31'b0, out_if.out_valid}, 32'h0);
    send(8'h5A);
    check("ldi_result", snap(), pack(1'b1, 4'd8, 2'b10, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 8'h5A));
`else
    check("ldi_illegal", snap(), pack(1'b1, 4'd9, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00));
    send(8'h5A);
    check("ldi_data_as_load", snap(), pack(1'b1, 4'd2, 2'b00, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 8'h0B));
`endif
    cyc();
    check("ldi_single_output", {31'b0, out_if.out_valid}, 32'h0);

    send(8'h27);
    flush          = 1'b1;
    in_if.in_valid = 1'b1;
    in_if.in_inst  = 8'hAA;
    cyc();
    flush          = 1'b0;
    in_if.in_valid = 1'b0;
    check("flush_drop", {31'b0, out_if.out_valid}, 32'h0);
    send(8'h02);
    check("flush_then_load", snap(), pack(1'b1, 4'd2, 2'b00, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00));

    send(8'h90);
    check("pre_reset_valid", {31'b0, out_if.out_valid}, 32'h1);
    #2 rst = 1'b1;
    #1;
    check("async_reset_outputs", snap(), 32'h0);
    check("async_reset_in_ready", {31'b0, in_if.in_ready}, 32'h1);
    cyc();
    rst = 1'b0;
    send(8'h27);
    #2 rst = 1'b1;
    #1;
    check("reset_in_prefix", {31'b0, out_if.out_valid}, 32'h0);
    cyc();
    rst = 1'b0;
    send(8'h02);
    check("post_reset_load", snap(), pack(1'b1, 4'd2, 2'b00, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
